// File: rtl/multi_channel_pwm_converter.sv
// multi_channel_pwm_converter
//
// Converts CHANNELS distance samples into PWM outputs driven from one shared period
// counter. Each channel's duty is proportional or inverse to its distance sample and
// saturates at MAX_COUNT. A new duty is latched only at a period wrap or a synchronous
// restart, so a pulse is never cut short or stretched mid-period.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   enable        clock enable; low holds every register
//   sync_restart  restart the period at cnt=0 and reload duties; overrides enable
//   distance      packed samples, channel c at [c*WIDTH +: WIDTH]
//   mode          per channel: 0 proportional, 1 inverse
//   ch_en         per channel enable; a disabled channel gets duty 0
//   pwm_out       registered PWM outputs
//   period_start  registered flag, high during the first cycle of each period

module multi_channel_pwm_converter #(
   parameter int unsigned WIDTH     = 13,
   parameter int unsigned MAX_COUNT = 3000,
   parameter int unsigned CHANNELS  = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      sync_restart,
   input  logic [CHANNELS*WIDTH-1:0] distance,
   input  logic [CHANNELS-1:0]       mode,
   input  logic [CHANNELS-1:0]       ch_en,
   output logic [CHANNELS-1:0]       pwm_out,
   output logic                      period_start
);

   localparam int unsigned CW   = $clog2(MAX_COUNT + 1);
   localparam int unsigned CMPW = (WIDTH > CW) ? WIDTH : CW;

   localparam logic [CMPW-1:0] MaxCmp  = CMPW'(MAX_COUNT);
   localparam logic [CW-1:0]   LastCnt = CW'(MAX_COUNT - 1);

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [CW-1:0]       duty_q [CHANNELS];
   logic [CW-1:0]       duty_d [CHANNELS];
   logic [CW-1:0]       target [CHANNELS];
   logic [CHANNELS-1:0] pwm_d;
   logic                wrap;
   logic                step;
   logic                reload;

   always_comb begin
      wrap   = (cnt_q == LastCnt);
      // Any edge that is not a hold edge updates the output registers.
      step   = sync_restart | enable;
      reload = sync_restart | (enable & wrap);
      cnt_d  = cnt_q;
      if (sync_restart) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = wrap ? '0 : cnt_q + CW'(1);
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [CMPW-1:0] dist_ext;
      logic [CMPW-1:0] dist_sat;

      assign dist_ext = CMPW'(distance[c*WIDTH +: WIDTH]);
      assign dist_sat = (dist_ext >= MaxCmp) ? MaxCmp : dist_ext;

      // dist_sat never exceeds MAX_COUNT, so narrowing to CW bits is lossless.
      assign target[c] = !ch_en[c] ? '0 :
                         mode[c]   ? CW'(MaxCmp - dist_sat) : CW'(dist_sat);

      assign duty_d[c] = reload ? target[c] : duty_q[c];

      // Outputs come from next-state values so they line up with the cycle cnt_d shows.
      assign pwm_d[c] = (CMPW'(cnt_d) < CMPW'(duty_d[c]));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q        <= '0;
         pwm_out      <= '0;
         period_start <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            duty_q[c] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         for (int c = 0; c < CHANNELS; c++) begin
            duty_q[c] <= duty_d[c];
         end
         if (step) begin
            pwm_out      <= pwm_d;
            period_start <= reload;
         end
      end
   end

endmodule
